// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding, store-size codes and default widths for the cache controller.
package cache_pkg;
    typedef enum logic [1:0] {IDLE, FILL, INSTALL, WRITE} state_t;
    localparam logic [1:0] WORD = 2'b00;
    localparam logic [1:0] BYTE = 2'b01;
    localparam logic [1:0] HALF = 2'b10;
    localparam int ASIZE = 32;
    localparam int DSIZE = 32;
    localparam int BBITS = 5;
    localparam int BSIZE = 8 << BBITS;
endpackage

// File: rtl/cache_stats.sv
// cache_stats: hit/miss event counters for the cache controller (built only with CACHE_STATS_EN).
//   CLK, RESET (async active-low)
//   hit_evt    : IDLE read that hits the core
//   miss_evt   : IDLE read that misses (IDLE->FILL)
//   fill_done  : INSTALL cycle; the read replayed right after it is not a hit
//   hit_count, miss_count : wrapping 32-bit counters
module cache_stats (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        hit_evt,
    input  logic        miss_evt,
    input  logic        fill_done,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);
    logic post_fill;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            post_fill  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            post_fill <= fill_done;
            if (hit_evt && !post_fill) hit_count <= hit_count + 32'd1;
            if (miss_evt) miss_count <= miss_count + 32'd1;
        end
    end
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: write-through, read-allocate controller between the CPU, a direct-mapped cache_core and memory.
//   CLK, RESET (async active-low)
//   cpu_*  : load/store request (held while cpu_stall), load data, stall
//   core_* : cache_core control; address/data pass straight from the CPU, block_in is the fill register
//   mem_*  : memory bus; request held until the one-cycle mem_ack
//   Optional macro CACHE_STATS_EN adds hit_count/miss_count outputs.
module cache_ctrl import cache_pkg::*; #(
    parameter int asize = ASIZE,
    parameter int dsize = DSIZE,
    parameter int bbits = BBITS,
    parameter int bsize = 8 << bbits
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             cpu_read,
    input  logic             cpu_write,
    input  logic [1:0]       cpu_wmode,
    input  logic [asize-1:0] cpu_addr,
    input  logic [dsize-1:0] cpu_wdata,
    output logic [dsize-1:0] cpu_rdata,
    output logic             cpu_stall,
    output logic             core_dread,
    output logic             core_dwrite,
    output logic [1:0]       core_dwmode,
    output logic             core_bwrite,
    output logic [asize-1:0] core_address,
    output logic [dsize-1:0] core_data_in,
    output logic [bsize-1:0] core_block_in,
    input  logic [dsize-1:0] core_data_out,
    input  logic             core_hit,
    output logic             mem_req,
    output logic             mem_we,
    output logic [asize-1:0] mem_addr,
    output logic [dsize-1:0] mem_wdata,
    output logic [1:0]       mem_wmode,
    input  logic             mem_ack,
    input  logic [bsize-1:0] mem_rblock
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]      hit_count,
    output logic [31:0]      miss_count
`endif
);
    state_t state;
    logic idle;
    logic miss;
    assign idle = state == IDLE;
    // a simultaneous store wins, so a read is only a read when no write is present
    assign miss = idle && cpu_read && !cpu_write && !core_hit;
    assign cpu_rdata = core_data_out;
    assign core_address = cpu_addr;
    assign core_data_in = cpu_wdata;
    assign core_dwmode = cpu_wmode;
    assign core_dread = idle && cpu_read;
    // gated by RESET so the store strobe stays low while reset is held
    assign core_dwrite = RESET && idle && cpu_write;
    assign cpu_stall = idle ? (cpu_write || (cpu_read && !core_hit)) : (state == WRITE) ? !mem_ack : 1'b1;
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state         <= IDLE;
            core_block_in <= '0;
            core_bwrite   <= 1'b0;
            mem_req       <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wmode     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cpu_write) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        mem_wmode <= cpu_wmode;
                    end else if (miss) begin
                        state    <= FILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {cpu_addr[asize-1:bbits], {bbits{1'b0}}};
                    end
                end
                FILL: begin
                    if (mem_ack) begin
                        state         <= INSTALL;
                        mem_req       <= 1'b0;
                        core_block_in <= mem_rblock;
                        core_bwrite   <= 1'b1;
                    end
                end
                INSTALL: begin
                    state       <= IDLE;
                    core_bwrite <= 1'b0;
                end
                WRITE: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef CACHE_STATS_EN
    cache_stats u_stats (
        .CLK        (CLK),
        .RESET      (RESET),
        .hit_evt    (idle && cpu_read && !cpu_write && core_hit),
        .miss_evt   (miss),
        .fill_done  (core_bwrite),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );
`endif
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: transaction-level reference bench for cache_ctrl with a behavioural core and memory.
module tb_cache_ctrl;
    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         cpu_read = 1'b0;
    logic         cpu_write = 1'b0;
    logic [1:0]   cpu_wmode = 2'b00;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         core_dread, core_dwrite, core_bwrite;
    logic [1:0]   core_dwmode;
    logic [31:0]  core_address, core_data_in;
    logic [255:0] core_block_in;
    logic [31:0]  core_data_out;
    logic         core_hit;
    logic         mem_req, mem_we;
    logic [31:0]  mem_addr, mem_wdata;
    logic [1:0]   mem_wmode;
    logic         mem_ack = 1'b0;
    logic [255:0] mem_rblock = '0;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count, miss_count;
`endif

    cache_ctrl dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_wmode(cpu_wmode),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
        .core_dread(core_dread), .core_dwrite(core_dwrite), .core_dwmode(core_dwmode),
        .core_bwrite(core_bwrite), .core_address(core_address), .core_data_in(core_data_in),
        .core_block_in(core_block_in), .core_data_out(core_data_out), .core_hit(core_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wmode(mem_wmode), .mem_ack(mem_ack), .mem_rblock(mem_rblock)
`ifdef CACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    always #5 CLK = ~CLK;

    // big-endian lane placement inside a word: byte offset 0 is bits 31:24
    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [1:0] m, input logic [1:0] off);
        logic [31:0] r;
        int o;
        r = old;
        o = int'(off);
        if (m == 2'b01) r[31-8*o -: 8] = d[7:0];
        else if (m == 2'b10) r[31-16*(o/2) -: 16] = d[15:0];
        else r = d;
        return r;
    endfunction

    // direct-mapped core: 8 lines of 32 bytes, tag = addr[31:8]
    logic         c_val [8] = '{default: 1'b0};
    logic [23:0]  c_tag [8];
    logic [255:0] c_blk [8];
    always_comb begin
        core_hit = c_val[core_address[7:5]] && c_tag[core_address[7:5]] == core_address[31:8];
        core_data_out = c_blk[core_address[7:5]][32*int'(core_address[4:2]) +: 32];
    end
    always @(posedge CLK) begin
        if (core_bwrite) begin
            c_val[core_address[7:5]] <= 1'b1;
            c_tag[core_address[7:5]] <= core_address[31:8];
            c_blk[core_address[7:5]] <= core_block_in;
        end else if (core_dwrite && core_hit) begin
            c_blk[core_address[7:5]][32*int'(core_address[4:2]) +: 32] <=
                merge(core_data_out, core_data_in, core_dwmode, core_address[1:0]);
        end
    end

    // architectural memory; unwritten words follow a fixed hash
    logic [31:0] mem [logic [29:0]];
    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem.exists(a[31:2])) return mem[a[31:2]];
        return ({a[31:2], 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction
    function automatic logic [255:0] rd_block(input logic [31:0] a);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = rd_word({a[31:5], 3'(i), 2'b00});
        return b;
    endfunction

    // reference residency and statistics, advanced per completed transaction
    logic        r_val [8] = '{default: 1'b0};
    logic [23:0] r_tag [8];
    int ref_hit = 0, ref_miss = 0;

    logic chk = 1'b0, chk_ma = 1'b0, chk_rd = 1'b0;
    logic e_stall, e_req, e_we, e_bw, e_dw, e_dread;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [1:0]  e_wmode;
    int n_cmp = 0, n_bad = 0;
    int n_stall = 0, n_bw = 0, n_dw = 0;
    logic [31:0] last_ma = '0, last_rd = '0;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (chk) begin
            cmp("cpu_stall", 32'(cpu_stall), 32'(e_stall));
            cmp("mem_req", 32'(mem_req), 32'(e_req));
            cmp("core_bwrite", 32'(core_bwrite), 32'(e_bw));
            cmp("core_dwrite", 32'(core_dwrite), 32'(e_dw));
            cmp("core_dread", 32'(core_dread), 32'(e_dread));
            if (e_req) cmp("mem_we", 32'(mem_we), 32'(e_we));
            if (chk_ma) cmp("mem_addr", mem_addr, e_addr);
            if (chk_ma && e_we) begin
                cmp("mem_wdata", mem_wdata, e_wdata);
                cmp("mem_wmode", 32'(mem_wmode), 32'(e_wmode));
            end
            if (chk_rd) cmp("cpu_rdata", cpu_rdata, e_rdata);
`ifdef CACHE_STATS_EN
            cmp("hit_count", hit_count, 32'(ref_hit));
            cmp("miss_count", miss_count, 32'(ref_miss));
`endif
        end
        if (cpu_stall) n_stall++;
        if (core_bwrite) n_bw++;
        if (core_dwrite) n_dw++;
        if (mem_req) last_ma = mem_addr;
        if (cpu_read && !cpu_write && !cpu_stall) last_rd = cpu_rdata;
    end

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    task automatic set_exp(input bit s, input bit rq, input bit we, input bit bw, input bit dw, input bit dr);
        e_stall = s; e_req = rq; e_we = we; e_bw = bw; e_dw = dw; e_dread = dr;
    endtask

    task automatic do_idle;
        cpu_read = 0; cpu_write = 0;
        mem_ack = ($urandom % 4) == 0;
        mem_rblock = {8{$urandom}};
        set_exp(0, 0, 0, 0, 0, 0);
        step;
        mem_ack = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input int lat);
        int ix;
        logic hit;
        ix = int'(a[7:5]);
        hit = r_val[ix] && r_tag[ix] == a[31:8];
        cpu_read = 1; cpu_write = 0; cpu_addr = a;
        cpu_wdata = $urandom; cpu_wmode = 2'($urandom);
        if (hit) begin
            set_exp(0, 0, 0, 0, 0, 1); chk_rd = 1; e_rdata = rd_word(a);
            step;
            ref_hit++;
        end else begin
            set_exp(1, 0, 0, 0, 0, 1);
            step;
            ref_miss++;
            for (int k = 1; k <= lat; k++) begin
                set_exp(1, 1, 0, 0, 0, 0); chk_ma = 1; e_addr = {a[31:5], 5'b0};
                mem_ack = (k == lat);
                mem_rblock = (k == lat) ? rd_block(a) : {8{$urandom}};
                step;
            end
            mem_ack = 0; chk_ma = 0;
            set_exp(1, 0, 0, 1, 0, 0);
            step;
            r_val[ix] = 1; r_tag[ix] = a[31:8];
            set_exp(0, 0, 0, 0, 0, 1); chk_rd = 1; e_rdata = rd_word(a);
            step;
        end
        chk_rd = 0; cpu_read = 0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [1:0] m,
                            input int lat, input bit wig);
        cpu_write = 1; cpu_read = 1'($urandom); cpu_addr = a; cpu_wdata = d; cpu_wmode = m;
        set_exp(1, 0, 0, 0, 1, cpu_read);
        step;
        for (int k = 1; k <= lat; k++) begin
            if (wig) begin cpu_addr = $urandom; cpu_wdata = $urandom; cpu_wmode = 2'($urandom); end
            set_exp(k < lat, 1, 1, 0, 0, 0); chk_ma = 1; e_addr = a; e_wdata = d; e_wmode = m;
            mem_ack = (k == lat);
            step;
        end
        mem_ack = 0; chk_ma = 0;
        mem[a[31:2]] = merge(rd_word(a), d, m, a[1:0]);
        cpu_write = 0; cpu_read = 0;
    endtask

    int s0, b0, d0;
    logic [31:0] ra;

    initial begin
        mem[30'(32'h1000 >> 2)] = 32'hDEADBEEF;
        mem[30'(32'h2000 >> 2)] = 32'h12345678;
        set_exp(0, 0, 0, 0, 0, 0);
        chk = 1;
        step;
        step;
        RESET = 1;
        do_idle;

        // 1: cold read miss, 3-cycle memory
        s0 = n_stall; b0 = n_bw;
        do_read(32'h0000_1000, 3);
        cmp("t1_stall_cycles", 32'(n_stall - s0), 32'd5);
        cmp("t1_bwrite_pulses", 32'(n_bw - b0), 32'd1);
        cmp("t1_rdata", last_rd, 32'hDEADBEEF);
        cmp("t1_mem_addr", last_ma, 32'h0000_1000);
        // 2: rehit in the same block
        s0 = n_stall;
        do_read(32'h0000_1004, 2);
        cmp("t2_stall_cycles", 32'(n_stall - s0), 32'd0);
`ifdef CACHE_STATS_EN
        cmp("t2_hit_count", hit_count, 32'd1);
        cmp("t2_miss_count", miss_count, 32'd1);
`endif
        do_idle;
        // 3: byte store hit, then reread
        d0 = n_dw;
        do_write(32'h0000_1001, 32'h0000_00AB, 2'b01, 2, 1'b0);
        cmp("t3_dwrite_pulses", 32'(n_dw - d0), 32'd1);
        cmp("t3_mem_addr", last_ma, 32'h0000_1001);
        do_read(32'h0000_1000, 2);
        cmp("t3_rdata", last_rd, 32'hDEABBEEF);
        // 4: store to an uncached block, then read it
        b0 = n_bw;
        do_write(32'h0000_2000, 32'h12345678, 2'b00, 3, 1'b0);
        cmp("t4_no_bwrite", 32'(n_bw - b0), 32'd0);
        s0 = n_stall;
        do_read(32'h0000_2000, 2);
        cmp("t4_stall_cycles", 32'(n_stall - s0), 32'd4);
        cmp("t4_rdata", last_rd, 32'h12345678);
        // 5: reset in the middle of a fill
        b0 = n_bw;
        cpu_read = 1; cpu_write = 0; cpu_addr = 32'h0000_3040;
        set_exp(1, 0, 0, 0, 0, 1);
        step;
        ref_miss++;
        for (int k = 1; k <= 2; k++) begin
            set_exp(1, 1, 0, 0, 0, 0); chk_ma = 1; e_addr = 32'h0000_3040;
            step;
        end
        chk_ma = 0;
        RESET = 0; ref_hit = 0; ref_miss = 0;
        set_exp(1, 0, 0, 0, 0, 1);
        step;
        RESET = 1;
        do_idle;
        cmp("t5_no_bwrite", 32'(n_bw - b0), 32'd0);
        s0 = n_stall;
        do_read(32'h0000_3040, 2);
        cmp("t5_refill_stall", 32'(n_stall - s0), 32'd4);
        // 6: CPU inputs wander while the write is outstanding
        do_write(32'h0000_1100, 32'hCAFEF00D, 2'b10, 4, 1'b1);
        do_idle;

        for (int t = 0; t < 300; t++) begin
            int op;
            op = $urandom_range(0, 9);
            ra = 32'h0000_1000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
            if (op < 6) do_read({ra[31:2], 2'b00}, $urandom_range(1, 5));
            else if (op < 9) do_write(ra, $urandom, 2'($urandom), $urandom_range(1, 5), 1'($urandom));
            else do_idle;
        end
        do_idle;
        chk = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cache_ctrl.md
Name: cache_ctrl

Overview:
Write-through, read-allocate controller that sequences one direct-mapped cache_core between the CPU pipeline and the memory bus.
- Read hits are served combinationally through the core.
- Read misses fetch a whole block from memory and install it with bwrite.
- Stores update the core on hit and are always written through to memory.
- The core's dirty bits stay unused in this configuration.
- Stalls the CPU while any memory transaction is outstanding.

Parameters:
asize, 32, address width
dsize, 32, CPU data width
bbits, 5, block offset bits (32-byte block)
bsize, 8<<bbits, block width in bits (256)

Ports:
CLK  input  1  clock, all state on rising edge
RESET  input  1  asynchronous active-low reset
cpu_read  input  1  load request, held until stall low
cpu_write  input  1  store request, held until stall low
cpu_wmode  input  2  01 byte, 10 half, other word
cpu_addr  input  asize  request address
cpu_wdata  input  dsize  store data
cpu_rdata  output  dsize  load data (= core_data_out)
cpu_stall  output  1  CPU must hold request
core_dread  output  1  to core dread
core_dwrite  output  1  to core dwrite
core_dwmode  output  2  to core dwmode
core_bwrite  output  1  to core bwrite
core_address  output  asize  to core address (= cpu_addr)
core_data_in  output  dsize  to core data_in (= cpu_wdata)
core_block_in  output  bsize  to core block_in (fill register)
core_data_out  input  dsize  from core data_out
core_hit  input  1  from core hit
mem_req  output  1  memory request, held until mem_ack
mem_we  output  1  1 = word/half/byte write, 0 = block read
mem_addr  output  asize  read: cpu_addr with low bbits zeroed; write: cpu_addr
mem_wdata  output  dsize  store data
mem_wmode  output  2  store size
mem_ack  input  1  one-cycle completion pulse
mem_rblock  input  bsize  read block, valid with mem_ack

Behaviour:
- States: IDLE, FILL, INSTALL, WRITE. Async reset → IDLE. Reset values: mem_req=0, mem_we=0, core_bwrite=0, core_dwrite=0, fill register=0.
- cpu_read and cpu_write together: write takes priority, read is ignored.
- IDLE, read, core_hit=1: cpu_stall=0 in the same cycle; 0-cycle latency.
- IDLE, read, core_hit=0: cpu_stall=1; go to FILL.
- FILL: mem_req=1, mem_we=0, block-aligned mem_addr, cpu_stall=1.
  - On mem_ack: latch mem_rblock into the fill register; go to INSTALL.
- INSTALL: core_bwrite=1 for exactly one cycle, cpu_stall=1; go to IDLE.
  - Next cycle the core hits and the stall drops.
  - Total miss latency = memory latency + 2 cycles.
- IDLE, write: cpu_stall=1; core_dwrite=1 for this cycle only; go to WRITE.
  - The core applies the store only if core_hit (no write-allocate).
- WRITE: mem_req=1, mem_we=1, cpu_stall=1 until mem_ack.
  - In the mem_ack cycle, cpu_stall=0; go to IDLE.
  - The store is not repeated to the core.
- core_dread = cpu_read in IDLE, 0 elsewhere. core_dwmode = cpu_wmode.
- mem_addr, mem_wdata and mem_wmode are registered on leaving IDLE. They stay stable while mem_req=1, even if CPU inputs change.
- mem_ack outside FILL/WRITE is ignored.
- Reset mid-transaction: immediate return to IDLE and mem_req drops. The pending fill is discarded and the core is not written.
- Core SYS flush is not driven here. The controller tolerates core_hit falling at any time; it is sampled only in IDLE.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], reset 0.
  - hit_count increments once per IDLE read with core_hit=1.
  - miss_count increments once per IDLE→FILL transition.
  - Both wrap at 2^32.
  - The read after INSTALL counts as neither a hit nor a miss.
- Undefined: no ports, no counter logic.

Decomposition:
- cache_pkg: state encoding (IDLE/FILL/INSTALL/WRITE), wmode constants (BYTE=01, HALF=10, WORD=00), default width constants.
- Sub-module cache_stats holds both counters. It is instantiated only under CACHE_STATS_EN.

Test Plan:
1. Reset, then read 0x00001000 (miss); memory acks after 3 cycles with a block whose word0=0xDEADBEEF → stall high for 5 cycles, one bwrite pulse, cpu_rdata=0xDEADBEEF, mem_addr=0x00001000.
2. Reread 0x00001004 after the fill → cpu_stall=0 on the same cycle, no mem_req; miss_count=1, hit_count=1 (stats build).
3. Byte store 0xAB to 0x00001001 (hit), ack after 2 cycles → one core_dwrite pulse, mem_we=1, mem_wmode=01, mem_addr=0x00001001; a following read of 0x00001000 returns 0xDEABBEEF.
4. Word store to uncached 0x00002000 → mem write issued, no bwrite; a following read of 0x00002000 misses and fills.
5. Assert RESET low during FILL before mem_ack → mem_req=0 immediately, state IDLE, no bwrite; a subsequent read of the same address misses again.
6. Change cpu_addr/cpu_wdata while in WRITE with ack delayed 4 cycles → mem_addr/mem_wdata hold their original values until ack.
